pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter NUM_REGS, default 16, SHALL set the number of architectural registers tracked.
REQ-002 Parameter ADDR_W, default 4, SHALL set the register address width.
REQ-003 Parameter FLUSH_CYCLES, default 2, SHALL set the number of cycles fetch/decode are killed after a mispredict.
REQ-004 Port clk  in  1  sole clock; all state SHALL update on its rising edge; one clock domain.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port id_valid  in  1  decode stage holds a valid instruction.
REQ-007 Port id_s1_used / id_s2_used  in  1 each  source operand 1 / 2 is read.
REQ-008 Port id_s1_addr / id_s2_addr  in  ADDR_W each  source register addresses.
REQ-009 Port id_dst_addr  in  ADDR_W  destination register of the decode instruction.
REQ-010 Port id_wrt_en  in  1  decode instruction writes id_dst_addr.
REQ-011 Port wb_wrt_en  in  1  writeback stage writes a register this cycle.
REQ-012 Port wb_addr  in  ADDR_W  writeback destination address.
REQ-013 Port ex_mispredict  in  1  execute stage resolved a branch/JAL as mispredicted this cycle.
REQ-014 Port issue_out  out  1  decode instruction advances to execute this cycle.
REQ-015 Port stall_out  out  1  hold PC and decode register this cycle.
REQ-016 Port flush_out  out  1  convert fetch/decode contents to bubbles this cycle.
REQ-017 Port stall_cnt  out  16  saturating count of stall cycles since reset.

Function
REQ-018 Block SHALL keep a NUM_REGS-bit scoreboard; bit n set means register n has an issued, unretired writer.
REQ-019 Source hazard SHALL be: sX_used AND scoreboard[sX_addr] AND NOT (wb_wrt_en AND wb_addr==sX_addr); same-cycle writeback resolves the hazard.
REQ-020 FSM states SHALL be RUN and FLUSH; FLUSH holds a down-counter loaded with FLUSH_CYCLES-1.
REQ-021 RUN -> FLUSH on ex_mispredict; FLUSH -> RUN when counter is 0 and ex_mispredict is low; ex_mispredict in FLUSH SHALL reload the counter.
REQ-022 issue_out SHALL be id_valid AND state==RUN AND NOT ex_mispredict AND no source hazard (combinational, zero latency).
REQ-023 stall_out SHALL be id_valid AND state==RUN AND NOT ex_mispredict AND source hazard present.
REQ-024 flush_out SHALL be 1 in the ex_mispredict cycle and in every FLUSH-state cycle; issue_out and stall_out SHALL be 0 whenever flush_out is 1.
REQ-025 On issue_out AND id_wrt_en, scoreboard[id_dst_addr] SHALL set at the next edge.
REQ-026 On wb_wrt_en, scoreboard[wb_addr] SHALL clear at the next edge; if the same address is also set by REQ-025, set SHALL win.
REQ-027 Mispredict SHALL NOT alter the scoreboard; already-issued instructions retire normally.
REQ-028 stall_cnt SHALL increment on each stall_out cycle and saturate at 16'hFFFF without wrap.

Reset
REQ-029 While reset is 1 at an edge: scoreboard SHALL clear, state SHALL be RUN, counter SHALL be 0, stall_cnt SHALL be 0.
REQ-030 While reset is 1, issue_out, stall_out and flush_out SHALL be forced to 0 regardless of inputs; reset mid-FLUSH SHALL abort the flush.

Structure
REQ-031 FSM state encoding and default FLUSH_CYCLES SHALL live in the shared pipeline package.
REQ-032 The scoreboard SHALL be one sub-module, reg_scoreboard (set port, clear port, two read ports with wb bypass).

Verification
REQ-033 Issue write r3, next cycle read r3 with no wb -> stall_out=1, stall_cnt increments; wb_wrt_en with wb_addr=3 -> issue_out=1 same cycle.
REQ-034 Issue write r5 while wb clears r5 same edge -> scoreboard[5]=1 afterwards; subsequent read of r5 stalls.
REQ-035 ex_mispredict=1 with FLUSH_CYCLES=2 -> flush_out=1 for exactly 3 cycles (mispredict cycle + 2), issue_out=0 throughout, RUN on cycle 4.
REQ-036 Second ex_mispredict in first FLUSH cycle -> counter reloads; flush_out stays 1 for 2 further cycles.
REQ-037 Force 65537 stall cycles -> stall_cnt holds 16'hFFFF.
REQ-038 Assert reset during FLUSH with r2 pending -> next cycle state RUN, flush_out=0, read of r2 issues without stall.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/flush controller: FSM encoding,
// default flush depth and the saturating stall-counter helper.
package pipeline_ctrl_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } pipe_state_t;

    localparam int FLUSH_CYCLES_DEFAULT = 2;
    localparam int STALL_CNT_W          = 16;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (v == {STALL_CNT_W{1'b1}}) ? v : v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Decode/writeback/execute signals seen by the pipeline controller, grouped so
// the pipeline (master) and the controller (slave) share one bundle.
interface pipeline_ctrl_if #(
    parameter int ADDR_W = 4
) ();
    import pipeline_ctrl_pkg::*;

    logic                   id_valid;
    logic                   id_s1_used;
    logic                   id_s2_used;
    logic [ADDR_W-1:0]      id_s1_addr;
    logic [ADDR_W-1:0]      id_s2_addr;
    logic [ADDR_W-1:0]      id_dst_addr;
    logic                   id_wrt_en;
    logic                   wb_wrt_en;
    logic [ADDR_W-1:0]      wb_addr;
    logic                   ex_mispredict;
    logic                   issue_out;
    logic                   stall_out;
    logic                   flush_out;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_s1_used, id_s2_used, id_s1_addr, id_s2_addr,
               id_dst_addr, id_wrt_en, wb_wrt_en, wb_addr, ex_mispredict,
        input  issue_out, stall_out, flush_out, stall_cnt
    );

    modport slave (
        input  id_valid, id_s1_used, id_s2_used, id_s1_addr, id_s2_addr,
               id_dst_addr, id_wrt_en, wb_wrt_en, wb_addr, ex_mispredict,
        output issue_out, stall_out, flush_out, stall_cnt
    );

endinterface

// File: rtl/pipeline_ctrl_reg_scoreboard.sv
// Pending-writer scoreboard: one bit per register, set on issue, cleared on
// writeback; reads see a same-cycle writeback as already retired.
module reg_scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] rd1_addr,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic              rd1_busy,
    output logic              rd2_busy
);

    logic [NUM_REGS-1:0] sb_q;
    logic [NUM_REGS-1:0] sb_d;

    // Set is applied after clear so a new writer wins over a retiring one.
    always_comb begin
        sb_d = sb_q;
        if (clr_en) sb_d[clr_addr] = 1'b0;
        if (set_en) sb_d[set_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) sb_q <= '0;
        else       sb_q <= sb_d;
    end

    assign rd1_busy = sb_q[rd1_addr] & ~(clr_en & (clr_addr == rd1_addr));
    assign rd2_busy = sb_q[rd2_addr] & ~(clr_en & (clr_addr == rd2_addr));

endmodule

// File: rtl/pipeline_ctrl.sv
// In-order pipeline controller: RAW-hazard stall via register scoreboard and
// fetch/decode flush sequencing after an execute-stage mispredict.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int NUM_REGS     = 16,
    parameter int ADDR_W       = 4,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    pipeline_ctrl_if.slave bus
);

    localparam int              CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    pipe_state_t            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic rd1_busy, rd2_busy;
    logic hazard, run_ok, issue, stall, flush;

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .set_en   (issue & bus.id_wrt_en),
        .set_addr (bus.id_dst_addr),
        .clr_en   (bus.wb_wrt_en),
        .clr_addr (bus.wb_addr),
        .rd1_addr (bus.id_s1_addr),
        .rd2_addr (bus.id_s2_addr),
        .rd1_busy (rd1_busy),
        .rd2_busy (rd2_busy)
    );

    // All handshake outputs are squashed while reset is held.
    always_comb begin
        hazard = (bus.id_s1_used & rd1_busy) | (bus.id_s2_used & rd2_busy);
        run_ok = bus.id_valid & (state_q == ST_RUN) & ~bus.ex_mispredict & ~reset;
        issue  = run_ok & ~hazard;
        stall  = run_ok & hazard;
        flush  = ~reset & (bus.ex_mispredict | (state_q == ST_FLUSH));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (bus.ex_mispredict) begin
                    state_d = ST_FLUSH;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_FLUSH: begin
                if (bus.ex_mispredict)  cnt_d   = CNT_LOAD;
                else if (cnt_q == '0)   state_d = ST_RUN;
                else                    cnt_d   = cnt_q - CNT_ONE;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.issue_out = issue;
    assign bus.stall_out = stall;
    assign bus.flush_out = flush;
    assign bus.stall_cnt = stall_cnt_q;

endmodule
